// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: constants and types shared by the hazard controller and
// its sub-module. The core decode emits the same Tuse/Tnew codes.
//   TUSE_NONE     : Tuse code for an operand that is never read
//   FWD_RF        : forward-select value meaning "take the register file"
//   STG_E/M/W     : scoreboard indices of the in-flight stages after D
//   *_CYC_DEF     : default MDU busy lengths
//   sb_entry_t    : one scoreboard slot {valid, a3, tnew, rs, rt}
//   sb_age()      : entry as it looks one stage later (tnew saturating at 0)
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam int         FWD_RF    = 0;

  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef struct packed {
    logic       valid;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (e.tnew != 2'd0) r.tnew = e.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational "youngest writer" search over the scoreboard.
// Entry 0 is the youngest. Register $0 never matches.
// Ports:
//   en       in  NSTAGE  per-entry qualifier (valid plus any caller filter)
//   a3       in  5 x N   destination register of each entry
//   tnew     in  2 x N   remaining Tnew of each entry
//   key      in  5       register being looked up
//   hit      out 1       a qualified entry writes key
//   idx      out IW      index of the youngest such entry
//   tnew_hit out 2       tnew of that entry
module hazard_match #(
  parameter  int NSTAGE = 3,
  localparam int IW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic [NSTAGE-1:0] en,
  input  logic [4:0]        a3   [NSTAGE],
  input  logic [1:0]        tnew [NSTAGE],
  input  logic [4:0]        key,
  output logic              hit,
  output logic [IW-1:0]     idx,
  output logic [1:0]        tnew_hit
);

  // Walk from oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    tnew_hit = 2'd0;
    if (key != 5'd0) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (en[k] && (a3[k] == key)) begin
          hit      = 1'b1;
          idx      = IW'(k);
          tnew_hit = tnew[k];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the pipelined MIPS core.
// Tracks in-flight writers (E..W) in a shifting scoreboard plus an MDU busy
// counter, and derives the D-stage stall and D/E forwarding selects.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   d_rs, d_rt            D-stage operand registers
//   d_tuse_rs, d_tuse_rt  cycles until the operand is needed (3 = unused)
//   d_wr, d_a3, d_tnew    D-stage destination write info
//   d_md_start, d_md_div  D instruction starts an MDU op (div selects length)
//   d_md_use              D instruction touches HI/LO or the MDU
//   stall                 freeze PC/D, bubble into E
//   fwd_rs_d, fwd_rt_d    D operand source: 0 = RF, k+1 = stage k register
//   fwd_rs_e, fwd_rt_e    E operand source: 0 = none, k+1 = stage k (k >= 1)
//   md_busy               MDU counter nonzero
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter  int NSTAGE   = 3,
  parameter  int MULT_CYC = MULT_CYC_DEF,
  parameter  int DIV_CYC  = DIV_CYC_DEF,
  localparam int FW       = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [1:0]    d_tuse_rs,
  input  logic [1:0]    d_tuse_rt,
  input  logic          d_wr,
  input  logic [4:0]    d_a3,
  input  logic [1:0]    d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  output logic          stall,
  output logic [FW-1:0] fwd_rs_d,
  output logic [FW-1:0] fwd_rt_d,
  output logic [FW-1:0] fwd_rs_e,
  output logic [FW-1:0] fwd_rt_e,
  output logic          md_busy
);

  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int CW = $clog2(DIV_CYC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

  sb_entry_t     sb_q [NSTAGE];
  logic [CW-1:0] cnt_q;

  logic [NSTAGE-1:0] en_d;
  logic [NSTAGE-1:0] en_e;
  logic [4:0]        a3_v   [NSTAGE];
  logic [1:0]        tnew_v [NSTAGE];

  // E forwarding only considers M and older stages whose result already
  // sits in the stage register.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      en_d[k]   = sb_q[k].valid;
      en_e[k]   = sb_q[k].valid && (k >= STG_M) && (sb_q[k].tnew == 2'd0);
      a3_v[k]   = sb_q[k].a3;
      tnew_v[k] = sb_q[k].tnew;
    end
  end

  logic          hit_rs_d, hit_rt_d, hit_rs_e, hit_rt_e;
  logic [IW-1:0] idx_rs_d, idx_rt_d, idx_rs_e, idx_rt_e;
  logic [1:0]    tn_rs_d,  tn_rt_d,  tn_rs_e,  tn_rt_e;

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rs_d (
    .en(en_d), .a3(a3_v), .tnew(tnew_v), .key(d_rs),
    .hit(hit_rs_d), .idx(idx_rs_d), .tnew_hit(tn_rs_d)
  );

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rt_d (
    .en(en_d), .a3(a3_v), .tnew(tnew_v), .key(d_rt),
    .hit(hit_rt_d), .idx(idx_rt_d), .tnew_hit(tn_rt_d)
  );

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rs_e (
    .en(en_e), .a3(a3_v), .tnew(tnew_v), .key(sb_q[STG_E].rs),
    .hit(hit_rs_e), .idx(idx_rs_e), .tnew_hit(tn_rs_e)
  );

  hazard_match #(.NSTAGE(NSTAGE)) u_match_rt_e (
    .en(en_e), .a3(a3_v), .tnew(tnew_v), .key(sb_q[STG_E].rt),
    .hit(hit_rt_e), .idx(idx_rt_e), .tnew_hit(tn_rt_e)
  );

  logic          stall_rs, stall_rt, stall_md, stall_raw;
  logic          busy_raw;
  logic [FW-1:0] sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e;

  always_comb begin
    busy_raw  = (cnt_q != '0);
    stall_rs  = hit_rs_d && (d_tuse_rs != TUSE_NONE) && (tn_rs_d > d_tuse_rs);
    stall_rt  = hit_rt_d && (d_tuse_rt != TUSE_NONE) && (tn_rt_d > d_tuse_rt);
    stall_md  = d_md_use && busy_raw;
    stall_raw = stall_rs || stall_rt || stall_md;

    sel_rs_d = FW'(FWD_RF);
    sel_rt_d = FW'(FWD_RF);
    sel_rs_e = FW'(FWD_RF);
    sel_rt_e = FW'(FWD_RF);
    if (hit_rs_d && (tn_rs_d == 2'd0)) sel_rs_d = FW'(idx_rs_d) + FW'(1);
    if (hit_rt_d && (tn_rt_d == 2'd0)) sel_rt_d = FW'(idx_rt_d) + FW'(1);
    if (hit_rs_e && (tn_rs_e == 2'd0)) sel_rs_e = FW'(idx_rs_e) + FW'(1);
    if (hit_rt_e && (tn_rt_e == 2'd0)) sel_rt_e = FW'(idx_rt_e) + FW'(1);
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    stall    = !reset && stall_raw;
    md_busy  = !reset && busy_raw;
    fwd_rs_d = reset ? '0 : sel_rs_d;
    fwd_rt_d = reset ? '0 : sel_rt_d;
    fwd_rs_e = reset ? '0 : sel_rs_e;
    fwd_rt_e = reset ? '0 : sel_rt_e;
  end

  sb_entry_t sb_in;

  always_comb begin
    sb_in       = '0;
    sb_in.valid = d_wr && (d_a3 != 5'd0);
    sb_in.a3    = d_a3;
    sb_in.tnew  = d_tnew;
    sb_in.rs    = d_rs;
    sb_in.rt    = d_rt;
  end

  // A stalled D instruction enters E as an all-zero bubble so its rs/rt
  // fields cannot pull a forward in E.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) sb_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 1; k < NSTAGE; k++) sb_q[k] <= sb_age(sb_q[k-1]);
      sb_q[STG_E] <= stall_raw ? '0 : sb_in;

      if (d_md_start && !stall_raw) cnt_q <= d_md_div ? DIV_LD : MULT_LD;
      else if (busy_raw)            cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wr, d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr(d_wr), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] rs, rt, a3;
    logic [1:0] tur, tut, tn;
    logic       wr, ms, md, mu;
  } ins_t;

  function automatic ins_t mk(int rs, int rt, int tur, int tut, int wr, int a3,
                              int tn, int ms, int md, int mu);
    ins_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.a3 = 5'(a3);
    i.tur = 2'(tur); i.tut = 2'(tut); i.tn = 2'(tn);
    i.wr = 1'(wr); i.ms = 1'(ms); i.md = 1'(md); i.mu = 1'(mu);
    return i;
  endfunction

  // Reference model: pipe[k] is the instruction k stages past D, kept with
  // its issue-time Tnew; its remaining Tnew is derived from its age.
  // The MDU is modelled as "busy through cycle busy_end".
  typedef struct { bit v; int a3; int tnew; int rs; int rt; } m_ins_t;
  m_ins_t pipe [NS];
  int     cyc      = 0;
  int     busy_end = -1;

  function automatic int rem_tnew(int k);
    int t;
    t = pipe[k].tnew - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int young_match(int r);
    if (r == 0) return -1;
    for (int k = 0; k < NS; k++)
      if (pipe[k].v && pipe[k].a3 == r) return k;
    return -1;
  endfunction

  function automatic int e_sel(int r);
    if (r == 0) return 0;
    for (int k = 1; k < NS; k++)
      if (pipe[k].v && pipe[k].a3 == r && rem_tnew(k) == 0) return k + 1;
    return 0;
  endfunction

  logic obs_stall, obs_busy;
  int   obs_frs_d, obs_frt_d;

  task automatic step(input bit rst, input ins_t i);
    int  mrs, mrt, e_frs_d, e_frt_d, e_frs_e, e_frt_e;
    bit  busy, s_rs, s_rt, s_md, e_stall;
    @(negedge clk);
    reset = rst;
    d_rs = i.rs; d_rt = i.rt; d_tuse_rs = i.tur; d_tuse_rt = i.tut;
    d_wr = i.wr; d_a3 = i.a3; d_tnew = i.tn;
    d_md_start = i.ms; d_md_div = i.md; d_md_use = i.mu;
    #1;
    mrs  = young_match(int'(i.rs));
    mrt  = young_match(int'(i.rt));
    busy = (cyc <= busy_end);
    s_rs = (mrs >= 0) && (i.tur != 2'd3) && (rem_tnew(mrs) > int'(i.tur));
    s_rt = (mrt >= 0) && (i.tut != 2'd3) && (rem_tnew(mrt) > int'(i.tut));
    s_md = i.mu && busy;
    e_stall = s_rs || s_rt || s_md;
    e_frs_d = (mrs >= 0 && rem_tnew(mrs) == 0) ? mrs + 1 : 0;
    e_frt_d = (mrt >= 0 && rem_tnew(mrt) == 0) ? mrt + 1 : 0;
    e_frs_e = e_sel(pipe[0].rs);
    e_frt_e = e_sel(pipe[0].rt);
    if (rst) begin
      e_stall = 0; busy = 0;
      e_frs_d = 0; e_frt_d = 0; e_frs_e = 0; e_frt_e = 0;
    end
    chk("stall",    int'(stall),    int'(e_stall));
    chk("md_busy",  int'(md_busy),  int'(busy));
    chk("fwd_rs_d", int'(fwd_rs_d), e_frs_d);
    chk("fwd_rt_d", int'(fwd_rt_d), e_frt_d);
    chk("fwd_rs_e", int'(fwd_rs_e), e_frs_e);
    chk("fwd_rt_e", int'(fwd_rt_e), e_frt_e);
    obs_stall = stall; obs_busy = md_busy;
    obs_frs_d = int'(fwd_rs_d); obs_frt_d = int'(fwd_rt_d);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NS; k++) pipe[k] = '{0, 0, 0, 0, 0};
      busy_end = cyc;
    end else begin
      for (int k = NS - 1; k > 0; k--) pipe[k] = pipe[k-1];
      if (e_stall) pipe[0] = '{0, 0, 0, 0, 0};
      else pipe[0] = '{i.wr && i.a3 != 0, int'(i.a3), int'(i.tn),
                       int'(i.rs), int'(i.rt)};
      if (i.ms && !e_stall) busy_end = cyc + (i.md ? 10 : 5);
    end
    cyc++;
  endtask

  // Re-present an instruction while it stalls; returns the stall count.
  task automatic until_go(input ins_t i, output int n);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      step(0, i);
      if (!obs_stall) return;
      n++;
    end
  endtask

  ins_t nop, ins;
  int   n;

  initial begin
    nop = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    step(1, nop); step(1, nop);
    chk("reset_busy", int'(obs_busy), 0);

    // lw $1 then add $2,$1,$3
    step(0, mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0));
    until_go(mk(1, 3, 1, 1, 1, 2, 1, 0, 0, 0), n);
    chk("t1_stall_cycles", n, 1);
    repeat (3) step(0, nop);

    // addu $1 then beq $1,$1
    step(0, mk(2, 3, 1, 1, 1, 1, 1, 0, 0, 0));
    until_go(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), n);
    chk("t2_stall_cycles", n, 1);
    chk("t2_fwd_rs_d", obs_frs_d, 2);
    chk("t2_fwd_rt_d", obs_frt_d, 2);
    repeat (3) step(0, nop);

    // ori $0 then beq $0,$0
    step(0, mk(0, 0, 1, 3, 1, 0, 1, 0, 0, 0));
    step(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("t3_stall", int'(obs_stall), 0);
    chk("t3_fwd_rs_d", obs_frs_d, 0);
    repeat (3) step(0, nop);

    // mult / div then mfhi; independent addu in the busy window
    step(0, mk(8, 9, 1, 1, 0, 0, 0, 1, 0, 1));
    until_go(mk(0, 0, 3, 3, 1, 4, 1, 0, 0, 1), n);
    chk("t4_mult_stalls", n, 5);
    step(0, mk(8, 9, 1, 1, 0, 0, 0, 1, 1, 1));
    until_go(mk(0, 0, 3, 3, 1, 4, 1, 0, 0, 1), n);
    chk("t4_div_stalls", n, 10);
    step(0, mk(8, 9, 1, 1, 0, 0, 0, 1, 0, 1));
    step(0, mk(10, 11, 1, 1, 1, 12, 1, 0, 0, 0));
    chk("t4_addu_stall", int'(obs_stall), 0);
    chk("t4_addu_busy", int'(obs_busy), 1);
    until_go(mk(0, 0, 3, 3, 1, 4, 1, 0, 0, 1), n);
    chk("t4_mfhi_after_addu", n, 4);
    repeat (3) step(0, nop);

    // div, reset mid-operation, then mflo
    step(0, mk(8, 9, 1, 1, 0, 0, 0, 1, 1, 1));
    step(0, nop); step(0, nop);
    step(1, nop);
    step(0, mk(0, 0, 3, 3, 1, 4, 1, 0, 0, 1));
    chk("t5_mflo_stall", int'(obs_stall), 0);
    chk("t5_busy", int'(obs_busy), 0);
    repeat (3) step(0, nop);

    // three writers of $5, youngest wins
    repeat (3) step(0, mk(0, 0, 3, 3, 1, 5, 0, 0, 0, 0));
    step(0, mk(5, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    chk("t6_stall", int'(obs_stall), 0);
    chk("t6_fwd_rs_d", obs_frs_d, 1);
    step(0, mk(0, 0, 3, 3, 1, 5, 0, 0, 0, 0));
    step(0, mk(0, 0, 3, 3, 1, 5, 2, 0, 0, 0));
    step(0, mk(5, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    chk("t6_young_stall", int'(obs_stall), 1);
    repeat (3) step(0, nop);
    // stall_rs and stall_md together
    step(0, mk(8, 9, 1, 1, 0, 0, 0, 1, 0, 1));
    step(0, mk(0, 0, 3, 3, 1, 5, 2, 0, 0, 0));
    step(0, mk(5, 0, 0, 3, 0, 0, 0, 0, 0, 1));
    chk("t6_combo_stall", int'(obs_stall), 1);

    // randomized traffic over a small register pool
    for (int t = 0; t < 3000; t++) begin
      ins.rs  = 5'($urandom_range(0, 7));
      ins.rt  = 5'($urandom_range(0, 7));
      ins.a3  = 5'($urandom_range(0, 7));
      ins.tur = 2'($urandom_range(0, 3));
      ins.tut = 2'($urandom_range(0, 3));
      ins.tn  = 2'($urandom_range(0, 3));
      ins.wr  = 1'($urandom_range(0, 1));
      ins.ms  = ($urandom_range(0, 9) == 0);
      ins.md  = 1'($urandom_range(0, 1));
      ins.mu  = ins.ms || ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 149) == 0, ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
